// File: rtl/dht11_responder.sv
// rtl/dht11_responder.sv - DHT11 sensor emulator answering a host start on an open-drain single-wire line
module dht11_responder #(
    parameter int T_START_MIN = 900000,
    parameter int T_GO        = 1500,
    parameter int T_RESP      = 4000,
    parameter int T_BIT_LOW   = 2500,
    parameter int T_ZERO      = 1300,
    parameter int T_ONE       = 3500
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        dht11,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    input  logic       corrupt_cksum,
    output logic       busy,
    output logic       frame_done,
    output logic       short_start,
    output logic [7:0] frame_count
);

    localparam int T_MAX_A = (T_GO > T_RESP) ? T_GO : T_RESP;
    localparam int T_MAX_B = (T_BIT_LOW > T_ONE) ? T_BIT_LOW : T_ONE;
    localparam int T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int T_MAX   = (T_MAX_C > T_ZERO) ? T_MAX_C : T_ZERO;
    localparam int CW      = $clog2(T_MAX + 1);
    localparam int LW      = $clog2(T_START_MIN + 1);

    // Phase counters run down from T-1 to 0, so each phase spans exactly T cycles.
    localparam logic [CW-1:0] GO_LD   = CW'(T_GO - 1);
    localparam logic [CW-1:0] RESP_LD = CW'(T_RESP - 1);
    localparam logic [CW-1:0] BLOW_LD = CW'(T_BIT_LOW - 1);
    localparam logic [CW-1:0] ZERO_LD = CW'(T_ZERO - 1);
    localparam logic [CW-1:0] ONE_LD  = CW'(T_ONE - 1);
    localparam logic [LW-1:0] LOW_MAX = LW'(T_START_MIN);

    typedef enum logic [2:0] {
        IDLE, HOST_LOW, GO_DELAY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [LW-1:0]  low_cnt, low_cnt_n;
    logic [5:0]     bit_idx, bit_idx_n;
    logic [39:0]    frame, frame_n;
    logic           armed, armed_n;
    logic           busy_n, frame_done_n, short_start_n, drive_low, drive_low_n;
    logic [7:0]     frame_count_n;
    logic           sync0, sync1, line_s, cnt_zero;
    logic [7:0]     sum, cksum;

    assign dht11  = drive_low ? 1'b0 : 1'bz;
    assign line_s = sync1;

    assign sum   = hum_int + hum_dec + temp_int + temp_dec;
    assign cksum = corrupt_cksum ? ~sum : sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync0 <= 1'b1;
            sync1 <= 1'b1;
        end else begin
            sync0 <= dht11;
            sync1 <= sync0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            low_cnt     <= '0;
            bit_idx     <= '0;
            frame       <= '0;
            armed       <= 1'b0;
            drive_low   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            short_start <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            low_cnt     <= low_cnt_n;
            bit_idx     <= bit_idx_n;
            frame       <= frame_n;
            armed       <= armed_n;
            drive_low   <= drive_low_n;
            busy        <= busy_n;
            frame_done  <= frame_done_n;
            short_start <= short_start_n;
            frame_count <= frame_count_n;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_zero      = (cnt == '0);
        cnt_n         = cnt_zero ? cnt : cnt - 1'b1;
        low_cnt_n     = low_cnt;
        bit_idx_n     = bit_idx;
        frame_n       = frame;
        armed_n       = armed;
        busy_n        = busy;
        frame_done_n  = 1'b0;
        short_start_n = 1'b0;
        frame_count_n = frame_count;

        case (state)
            // A high sample must be seen first so our own END_LOW cannot re-trigger us.
            IDLE: begin
                if (line_s) begin
                    armed_n = 1'b1;
                end else if (armed) begin
                    state_n   = HOST_LOW;
                    low_cnt_n = LW'(1);
                    armed_n   = 1'b0;
                end
            end
            HOST_LOW: begin
                if (!line_s) begin
                    if (low_cnt != LOW_MAX) low_cnt_n = low_cnt + 1'b1;
                end else if (low_cnt >= LOW_MAX) begin
                    state_n = GO_DELAY;
                    cnt_n   = GO_LD;
                    busy_n  = 1'b1;
                    frame_n = {hum_int, hum_dec, temp_int, temp_dec, cksum};
                end else begin
                    state_n       = IDLE;
                    short_start_n = 1'b1;
                end
            end
            GO_DELAY: begin
                if (cnt_zero) begin
                    state_n = RESP_LOW;
                    cnt_n   = RESP_LD;
                end
            end
            RESP_LOW: begin
                if (cnt_zero) begin
                    state_n = RESP_HIGH;
                    cnt_n   = RESP_LD;
                end
            end
            RESP_HIGH: begin
                if (cnt_zero) begin
                    state_n   = BIT_LOW;
                    cnt_n     = BLOW_LD;
                    bit_idx_n = '0;
                end
            end
            BIT_LOW: begin
                if (cnt_zero) begin
                    state_n = BIT_HIGH;
                    cnt_n   = frame[39] ? ONE_LD : ZERO_LD;
                end
            end
            // The frame shifts left after each bit so the current bit is always frame[39].
            BIT_HIGH: begin
                if (cnt_zero) begin
                    frame_n = {frame[38:0], 1'b0};
                    cnt_n   = BLOW_LD;
                    if (bit_idx == 6'd39) begin
                        state_n = END_LOW;
                    end else begin
                        state_n   = BIT_LOW;
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            END_LOW: begin
                if (cnt_zero) begin
                    state_n       = IDLE;
                    busy_n        = 1'b0;
                    frame_done_n  = 1'b1;
                    frame_count_n = frame_count + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        drive_low_n = (state_n == RESP_LOW) || (state_n == BIT_LOW) || (state_n == END_LOW);
    end

endmodule
